// File: rtl/mobius_iter_pkg.sv
// Shared definitions for the iterative Mobius transform: FSM state encoding,
// stage-counter sizing and the per-stage butterfly partner distance.
package mobius_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // The counter must be able to hold log2_n itself so it never wraps mid-transaction.
    function automatic int stage_cnt_width(input int log2n);
        return (log2n < 1) ? 1 : $clog2(log2n + 1);
    endfunction

    // Stage s pairs index i with i - mask whenever (i & mask) != 0.
    function automatic int partner_mask(input int n, input int s);
        return n >> (s + 1);
    endfunction

endpackage

// File: rtl/mobius_iter_if.sv
// Valid/ready bundle between the ANF producer, the transform engine and the
// truth-table consumer. The engine takes the slave modport.
interface mobius_iter_if #(
    parameter int N = 256
);
    logic         in_valid;
    logic         in_ready;
    logic [0:N-1] in_anf;
    logic         out_valid;
    logic         out_ready;
    logic [0:N-1] out_tt;
    logic         busy;

    modport master (
        output in_valid,
        output in_anf,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_tt,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_anf,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_tt,
        output busy
    );
endinterface

// File: rtl/mobius_iter_stage_var.sv
// One combinational GF(2) Mobius butterfly stage selected at run time by
// 'stage'; with en low the vector passes through unchanged.
module mobius_stage_var
    import mobius_pkg::*;
#(
    parameter int N      = 256,
    parameter int LOG2_N = 8,
    localparam int CW    = stage_cnt_width(LOG2_N)
) (
    input  logic          en,
    input  logic [CW-1:0] stage,
    input  logic [0:N-1]  d_in,
    output logic [0:N-1]  d_out
);

    logic [LOG2_N-1:0] sel;

    for (genvar k = 0; k < LOG2_N; k++) begin : g_sel
        assign sel[k] = en && (stage == CW'(k));
    end

    // Each bit folds in at most one partner, picked by whichever stage is selected.
    for (genvar i = 0; i < N; i++) begin : g_bit
        logic [LOG2_N-1:0] contrib;

        for (genvar k = 0; k < LOG2_N; k++) begin : g_stage
            localparam int M = partner_mask(N, k);
            if ((i & M) != 0) begin : g_pair
                assign contrib[k] = sel[k] & d_in[i - M];
            end else begin : g_none
                assign contrib[k] = 1'b0;
            end
        end

        assign d_out[i] = d_in[i] ^ (|contrib);
    end

endmodule

// File: rtl/mobius_iter.sv
// Iterative Mobius (ANF <-> truth table) engine reusing one butterfly stage per cycle.
// Define MOBIUS_ITER_TWO_STAGE_EN to chain two stages and apply two per cycle.
module mobius_iter
    import mobius_pkg::*;
#(
    parameter int N      = 256,
    parameter int LOG2_N = 8
) (
    input  logic          clk,
    input  logic          rst,
    mobius_iter_if.slave  bus
);

    localparam int CW = stage_cnt_width(LOG2_N);

    state_t        state;
    logic [0:N-1]  data;
    logic [CW-1:0] stage;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic [0:N-1]  stage_out;
    logic          last;

`ifdef MOBIUS_ITER_TWO_STAGE_EN
    localparam int STEP = 2;

    logic [0:N-1]  mid;
    logic [CW-1:0] stage_b;
    logic          en_b;

    // The second stage sits idle on the final cycle when log2_N is odd.
    assign stage_b = stage + CW'(1);
    assign en_b    = (stage_b < CW'(LOG2_N));
    assign last    = (stage_b >= CW'(LOG2_N - 1));

    mobius_stage_var #(.N(N), .LOG2_N(LOG2_N)) u_stage_a (
        .en    (1'b1),
        .stage (stage),
        .d_in  (data),
        .d_out (mid)
    );

    mobius_stage_var #(.N(N), .LOG2_N(LOG2_N)) u_stage_b (
        .en    (en_b),
        .stage (stage_b),
        .d_in  (mid),
        .d_out (stage_out)
    );
`else
    localparam int STEP = 1;

    assign last = (stage == CW'(LOG2_N - 1));

    mobius_stage_var #(.N(N), .LOG2_N(LOG2_N)) u_stage (
        .en    (1'b1),
        .stage (stage),
        .d_in  (data),
        .d_out (stage_out)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            data        <= '0;
            stage       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        data       <= bus.in_anf;
                        stage      <= '0;
                        state      <= ST_RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    data <= stage_out;
                    // Park the counter at log2_N rather than stepping past it.
                    if (last) begin
                        stage       <= CW'(LOG2_N);
                        state       <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        stage <= stage + CW'(STEP);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Reset must also mask in_ready combinationally so nothing is offered while rst is high.
    assign bus.in_ready  = in_ready_q & ~rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_tt    = data;
    assign bus.busy      = busy_q;

endmodule
